// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe -- registered ALU with a valid/ready handshake on both sides.
//
// Single-cycle ops (add, subtract in both operand orders, logic ops, pass-b,
// not-b) produce a registered result on the cycle after the transfer. With
// ALU_PIPE_MUL_EN defined, opcode 0011 is an unsigned shift-add multiply
// taking WIDTH BUSY cycles. Without the macro, 0011 is an illegal opcode and
// the multiply datapath does not exist.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   synchronous, active-low reset
//   in_valid   in   operation presented on a/b/operation
//   in_ready   out  operation can be accepted this cycle
//   a, b       in   WIDTH-bit operands
//   operation  in   4-bit opcode
//   out_valid  out  result/flags/illegal hold a valid result
//   out_ready  in   consumer takes the result
//   result     out  WIDTH-bit registered result
//   flags      out  registered {overflow, carry, negative, zero}
//   illegal    out  registered, accepted opcode was undefined
// -----------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             illegal
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] result_reg;
    logic [3:0]       flags_reg;
    logic             illegal_reg;
    logic             transfer;

    // Single-cycle datapath, evaluated on the live inputs and only
    // registered on a transfer.
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_ba;
    logic [WIDTH:0]   sub_ab;
    logic [WIDTH-1:0] alu_result_next;
    logic [3:0]       alu_flags_next;
    logic             alu_illegal_next;
    logic             alu_carry;
    logic             alu_ovf;

    assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign out_valid = (state_reg == DONE);
    assign transfer  = in_valid && in_ready;
    assign result    = result_reg;
    assign flags     = flags_reg;
    assign illegal   = illegal_reg;

    // The extra top bit of each subtraction is the borrow: it is set exactly
    // when the minuend is below the subtrahend as unsigned values.
    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_ba   = {1'b0, b} - {1'b0, a};
    assign sub_ab   = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_result_next  = '0;
        alu_carry        = 1'b0;
        alu_ovf          = 1'b0;
        alu_illegal_next = 1'b0;
        case (operation)
            4'b0000: begin
                alu_result_next = add_full[WIDTH-1:0];
                alu_carry       = add_full[WIDTH];
                alu_ovf         = (a[WIDTH-1] == b[WIDTH-1]) &&
                                  (add_full[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0101: begin
                alu_result_next = sub_ba[WIDTH-1:0];
                alu_carry       = sub_ba[WIDTH];
                alu_ovf         = (b[WIDTH-1] != a[WIDTH-1]) &&
                                  (sub_ba[WIDTH-1] != b[WIDTH-1]);
            end
            4'b0110: begin
                alu_result_next = sub_ab[WIDTH-1:0];
                alu_carry       = sub_ab[WIDTH];
                alu_ovf         = (a[WIDTH-1] != b[WIDTH-1]) &&
                                  (sub_ab[WIDTH-1] != a[WIDTH-1]);
            end
            4'b1000: alu_result_next = a & b;
            4'b1001: alu_result_next = a | b;
            4'b1100: alu_result_next = a ^ b;
            4'b1101: alu_result_next = b;
            4'b1010: alu_result_next = a & ~b;
            4'b1011: alu_result_next = a | ~b;
            4'b1110: alu_result_next = a ^ ~b;
            4'b1111: alu_result_next = ~b;
            default: alu_illegal_next = 1'b1;
        endcase

        if (alu_illegal_next) begin
            alu_flags_next = 4'b0001;
        end else begin
            alu_flags_next = {alu_ovf, alu_carry, alu_result_next[WIDTH-1],
                              (alu_result_next == '0)};
        end
    end

`ifdef ALU_PIPE_MUL_EN
    // Shift-add multiplier: each BUSY cycle adds the shifted multiplicand
    // when the current multiplier LSB is set. The accumulator is 2*WIDTH
    // wide so the upper half is available for the carry flag.
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0]   count_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] mul_sum;

    assign mul_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            result_reg  <= '0;
            flags_reg   <= '0;
            illegal_reg <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            count_reg   <= '0;
            mcand_reg   <= '0;
            acc_reg     <= '0;
            mplier_reg  <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (transfer) begin
`ifdef ALU_PIPE_MUL_EN
                        if (operation == 4'b0011) begin
                            state_reg  <= BUSY;
                            count_reg  <= '0;
                            mcand_reg  <= {{WIDTH{1'b0}}, a};
                            mplier_reg <= b;
                            acc_reg    <= '0;
                        end else
`endif
                        begin
                            state_reg   <= DONE;
                            result_reg  <= alu_result_next;
                            flags_reg   <= alu_flags_next;
                            illegal_reg <= alu_illegal_next;
                        end
                    end else if ((state_reg == DONE) && out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                BUSY: begin
`ifdef ALU_PIPE_MUL_EN
                    acc_reg    <= mul_sum;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    count_reg  <= count_reg + CNT_W'(1);
                    // The last iteration's sum is the full product.
                    if (count_reg == CNT_W'(WIDTH - 1)) begin
                        state_reg   <= DONE;
                        result_reg  <= mul_sum[WIDTH-1:0];
                        flags_reg   <= {1'b0, (mul_sum[2*WIDTH-1:WIDTH] != '0),
                                        mul_sum[WIDTH-1], (mul_sum[WIDTH-1:0] == '0)};
                        illegal_reg <= 1'b0;
                    end
`else
                    // Unreachable without the multiplier; recover to IDLE.
                    state_reg <= IDLE;
`endif
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe -- self-checking bench for alu_pipe (WIDTH=32).
// Directed vector table, hand-written handshake/reset/multiply sequences and
// randomized operations compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_pipe;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   operation;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;
    logic         illegal;

    int n_checks = 0;
    int n_fail   = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .operation (operation),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] res;
        logic [3:0]   flg;
        logic         ill;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on 64-bit quantities.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] x,
                                  input logic [W-1:0] y, output logic [W-1:0] r,
                                  output logic [3:0] f, output logic il);
        longint sx;
        longint sy;
        longint s;
        logic [63:0] wide;
        logic c;
        logic v;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        c = 1'b0;
        v = 1'b0;
        il = 1'b0;
        r = '0;
        case (op)
            4'h0: begin
                wide = {32'd0, x} + {32'd0, y};
                r = wide[31:0];
                c = wide[32];
                s = sx + sy;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h5: begin
                r = y - x;
                c = (y < x);
                s = sy - sx;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h6: begin
                r = x - y;
                c = (x < y);
                s = sx - sy;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h8: r = x & y;
            4'h9: r = x | y;
            4'hC: r = x ^ y;
            4'hD: r = y;
            4'hA: r = x & ~y;
            4'hB: r = x | ~y;
            4'hE: r = x ^ ~y;
            4'hF: r = ~y;
`ifdef ALU_PIPE_MUL_EN
            4'h3: begin
                wide = {32'd0, x} * {32'd0, y};
                r = wide[31:0];
                c = (wide[63:32] != 32'd0);
            end
`endif
            default: il = 1'b1;
        endcase
        if (il) f = 4'b0001;
        else    f = {v, c, r[W-1], (r == '0)};
    endfunction

    function automatic int exp_lat(input logic [3:0] op);
`ifdef ALU_PIPE_MUL_EN
        if (op == 4'h3) return W;
`endif
        return 0;
    endfunction

    // Issue one operation with out_ready=1; returns the captured outputs and
    // the number of extra cycles between transfer+1 and out_valid.
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic [3:0] f,
                         output logic il, output int lat);
        int guard;
        @(negedge clk);
        operation = op;
        a = x;
        b = y;
        in_valid = 1'b1;
        out_ready = 1'b1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        // Scramble inputs after the transfer; they must have no effect.
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        operation = 4'($urandom);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        r = result;
        f = flags;
        il = illegal;
    endtask

    initial begin
        logic [W-1:0] r;
        logic [W-1:0] er;
        logic [3:0]   f;
        logic [3:0]   ef;
        logic         il;
        logic         eil;
        int           lat;
        int           cnt;
        logic [3:0]   pop;
        logic [W-1:0] px;
        logic [W-1:0] py;
        logic [3:0]   legal_ops[11];

        legal_ops = '{4'h0, 4'h5, 4'h6, 4'h8, 4'h9, 4'hC, 4'hD, 4'hA, 4'hB, 4'hE, 4'hF};

        tbl[0]  = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0101, 1'b0};
        tbl[1]  = '{4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b1000, 1'b0};
        // 1 - (-2^31) = 2^31+1 does not fit a signed 32-bit value: overflow set.
        tbl[2]  = '{4'b0101, 32'h80000000, 32'h00000001, 32'h80000001, 4'b1110, 1'b0};
        tbl[3]  = '{4'b0001, 32'h00000005, 32'h00000003, 32'h00000000, 4'b0001, 1'b1};
        tbl[4]  = '{4'b1000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0010, 1'b0};
        tbl[5]  = '{4'b1001, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000, 1'b0};
        tbl[6]  = '{4'b1100, 32'hAAAA5555, 32'hAAAA5555, 32'h00000000, 4'b0001, 1'b0};
        tbl[7]  = '{4'b1101, 32'h12345678, 32'h80000000, 32'h80000000, 4'b0010, 1'b0};
        tbl[8]  = '{4'b1010, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00000, 4'b0010, 1'b0};
        tbl[9]  = '{4'b1011, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 4'b0001, 1'b0};
        tbl[10] = '{4'b1110, 32'h12345678, 32'h12345678, 32'hFFFFFFFF, 4'b0010, 1'b0};
        tbl[11] = '{4'b1111, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 4'b0001, 1'b0};
        tbl[12] = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1010, 1'b0};
        tbl[13] = '{4'b0110, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b0110, 1'b0};
        tbl[14] = '{4'b0101, 32'h00000003, 32'h00000005, 32'h00000002, 4'b0000, 1'b0};
        tbl[15] = '{4'b0111, 32'h00000001, 32'h00000001, 32'h00000000, 4'b0001, 1'b1};
        tbl[16] = '{4'b0000, 32'h00000001, 32'h00000001, 32'h00000002, 4'b0000, 1'b0};

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        operation = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_flags", 64'(flags), 64'd0);
        check("reset_illegal", 64'(illegal), 64'd0);

        // ---------------- directed vector table ----------------
        for (int i = 0; i < 17; i++) begin
            do_op(tbl[i].op, tbl[i].x, tbl[i].y, r, f, il, lat);
            $display("vec%0d op=%b a=%h b=%h -> result=%h flags=%b illegal=%b",
                     i, tbl[i].op, tbl[i].x, tbl[i].y, r, f, il);
            check($sformatf("vec%0d_result", i), 64'(r), 64'(tbl[i].res));
            check($sformatf("vec%0d_flags", i), 64'(f), 64'(tbl[i].flg));
            check($sformatf("vec%0d_illegal", i), 64'(il), 64'(tbl[i].ill));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd0);
        end

        // ---------------- hold with out_ready low ----------------
        @(negedge clk);
        operation = 4'b1000;
        a = 32'hF0F0F0F0;
        b = 32'hFF00FF00;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        operation = 4'b0000;  // still presented, must not be taken while held
        a = 32'h1;
        b = 32'h1;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1 && in_ready === 1'b0 && result === 32'hF000F000
                && flags === 4'b0010)
                cnt++;
        end
        $display("hold: %0d of 5 cycles held result=%h with in_ready low", cnt, result);
        check("hold_cycles", 64'(cnt), 64'd5);
        out_ready = 1'b1;
        #1;
        check("hold_release_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        // The ADD presented during release is accepted (DONE -> DONE).
        $display("release+add: out_valid=%b result=%h", out_valid, result);
        check("release_add_valid", 64'(out_valid), 64'd1);
        check("release_add_result", 64'(result), 64'd2);
        in_valid = 1'b0;

        // ---------------- back-to-back throughput ----------------
        @(negedge clk);
        pop = legal_ops[$urandom_range(10, 0)];
        px = $urandom;
        py = $urandom;
        operation = pop;
        a = px;
        b = py;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            model(pop, px, py, er, ef, eil);
            $display("b2b%0d op=%b a=%h b=%h -> valid=%b result=%h flags=%b",
                     k, pop, px, py, out_valid, result, flags);
            check($sformatf("b2b%0d_valid", k), 64'(out_valid), 64'd1);
            check($sformatf("b2b%0d_result", k), 64'(result), 64'(er));
            check($sformatf("b2b%0d_flags", k), 64'(flags), 64'(ef));
            check($sformatf("b2b%0d_in_ready", k), 64'(in_ready), 64'd1);
            pop = legal_ops[$urandom_range(10, 0)];
            px = $urandom;
            py = $urandom;
            operation = pop;
            a = px;
            b = py;
            if (k == 7) in_valid = 1'b0;
        end

        // ---------------- reset while holding, overlapping a transfer ----------------
        @(negedge clk);
        operation = 4'b1001;
        a = 32'h00FF0000;
        b = 32'h0000FF00;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        operation = 4'b0000;
        a = 32'h1;
        b = 32'h2;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        $display("reset over held result + transfer: out_valid=%b result=%h in_ready=%b",
                 out_valid, result, in_ready);
        check("rst_hold_out_valid", 64'(out_valid), 64'd0);
        check("rst_hold_result", 64'(result), 64'd0);
        check("rst_hold_flags", 64'(flags), 64'd0);
        check("rst_hold_in_ready", 64'(in_ready), 64'd1);

`ifdef ALU_PIPE_MUL_EN
        // ---------------- multiply: busy window and latency ----------------
        @(negedge clk);
        operation = 4'b0011;
        a = 32'd7;
        b = 32'd6;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cnt = 0;
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            if (!in_ready) cnt++;
            @(negedge clk);
            lat++;
        end
        $display("mul 7*6: busy cycles=%0d result=%0d flags=%b", cnt, result, flags);
        check("mul_busy_in_ready_low", 64'(cnt), 64'd32);
        check("mul_latency", 64'(lat), 64'd32);
        check("mul_7x6_result", 64'(result), 64'd42);
        check("mul_7x6_flags", 64'(flags), 64'd0);

        do_op(4'b0011, 32'h00010000, 32'h00010000, r, f, il, lat);
        $display("mul 0x10000^2: result=%h flags=%b", r, f);
        check("mul_hi_result", 64'(r), 64'd0);
        check("mul_hi_flags", 64'(f), 64'b0101);

        // ---------------- reset during BUSY cycle 10 ----------------
        @(negedge clk);
        operation = 4'b0011;
        a = 32'd9;
        b = 32'd9;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        $display("reset in busy: out_valid=%b result=%h in_ready=%b", out_valid, result, in_ready);
        check("rst_busy_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy_result", 64'(result), 64'd0);
        check("rst_busy_in_ready", 64'(in_ready), 64'd1);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("rst_busy_no_late_output", 64'(cnt), 64'd0);
`endif

        // ---------------- randomized operations ----------------
        for (int i = 0; i < 150; i++) begin
            pop = 4'($urandom);
            case ($urandom_range(3, 0))
                0: px = 32'h80000000;
                1: px = 32'hFFFFFFFF;
                default: px = $urandom;
            endcase
            case ($urandom_range(3, 0))
                0: py = 32'h00000000;
                1: py = 32'h7FFFFFFF;
                default: py = $urandom;
            endcase
            do_op(pop, px, py, r, f, il, lat);
            model(pop, px, py, er, ef, eil);
            $display("rnd%0d op=%b a=%h b=%h -> result=%h flags=%b illegal=%b lat=%0d",
                     i, pop, px, py, r, f, il, lat);
            check($sformatf("rnd%0d_result", i), 64'(r), 64'(er));
            check($sformatf("rnd%0d_flags", i), 64'(f), 64'(ef));
            check($sformatf("rnd%0d_illegal", i), 64'(il), 64'(eil));
            check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(exp_lat(pop)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
